// File: rtl/charlie7x5_decoder.sv
// charlie7x5_decoder: decodes a sampled 7-pin charlieplex bus into 42-LED frame snapshots per window; CHARLIE7X5_DECODER_STATS_EN adds window statistics
module charlie7x5_decoder #(
  parameter int WINDOW_TICKS = 4096,
  parameter int ERR_W = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [6:0]                      charlie7x5_o,
  input  logic [6:0]                      charlie7x5_oe,
  output logic [41:0]                     frame_o,
  output logic                            frame_valid_o,
  input  logic                            frame_ready_i,
  output logic                            overrun_o,
  output logic [ERR_W-1:0]                conflict_cnt_o
`ifdef CHARLIE7X5_DECODER_STATS_EN
  ,
  output logic [$clog2(WINDOW_TICKS):0]   active_cycles_o,
  output logic [2:0]                      max_lit_o
`endif
);
  localparam int CW = $clog2(WINDOW_TICKS);
  logic [6:0] s_o, s_oe, an, ca;
  logic [41:0] acc, lit, snap;
  logic [CW-1:0] cnt;
  logic one_an, conflict, win_end, accept;
  assign an = s_oe & s_o;
  assign ca = s_oe & ~s_o;
  assign one_an = $onehot(an);
  assign conflict = !$onehot0(an) && |ca;
  assign snap = acc | lit;
  assign win_end = cnt == CW'(WINDOW_TICKS - 1);
  assign accept = !frame_valid_o || frame_ready_i;
  // the anode's own pin is skipped, so cathodes above it shift down by one
  always_comb begin
    lit = '0;
    for (int a = 0; a < 7; a++)
      for (int c = 0; c < 7; c++)
        if (c != a) lit[a*6 + (c < a ? c : c - 1)] = one_an & an[a] & ca[c];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_o <= '0;
      s_oe <= '0;
      cnt <= '0;
      acc <= '0;
      frame_o <= '0;
      frame_valid_o <= 1'b0;
      overrun_o <= 1'b0;
      conflict_cnt_o <= '0;
    end else begin
      s_o <= charlie7x5_o;
      s_oe <= charlie7x5_oe;
      cnt <= win_end ? '0 : cnt + 1'b1;
      acc <= win_end ? '0 : snap;
      if (conflict && !(&conflict_cnt_o)) conflict_cnt_o <= conflict_cnt_o + 1'b1;
      if (win_end && accept) begin
        frame_o <= snap;
        frame_valid_o <= 1'b1;
      end else if (win_end) overrun_o <= 1'b1;
      else if (frame_ready_i) frame_valid_o <= 1'b0;
    end
  end
`ifdef CHARLIE7X5_DECODER_STATS_EN
  logic [CW:0] act_cnt, act_next;
  logic [2:0] mx, cur, mx_next;
  assign cur = 3'($countones(lit));
  assign act_next = act_cnt + (CW+1)'(|lit);
  assign mx_next = cur > mx ? cur : mx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_cnt <= '0;
      mx <= '0;
      active_cycles_o <= '0;
      max_lit_o <= '0;
    end else begin
      act_cnt <= win_end ? '0 : act_next;
      mx <= win_end ? '0 : mx_next;
      if (win_end && accept) begin
        active_cycles_o <= act_next;
        max_lit_o <= mx_next;
      end
    end
  end
`endif
endmodule

// File: tb/tb_charlie7x5_decoder.sv
// tb_charlie7x5_decoder: table vectors, directed corner sequences and random traffic against a window-level reference model
module tb_charlie7x5_decoder;
  localparam int W = 16;
  logic clk = 0, rst = 1, ready = 1;
  logic [6:0] pin_o = '0, pin_oe = '0;
  logic [41:0] frame_o;
  logic frame_valid_o, overrun_o;
  logic [7:0] conflict_cnt_o;
  charlie7x5_decoder #(.WINDOW_TICKS(W), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .charlie7x5_o(pin_o), .charlie7x5_oe(pin_oe),
    .frame_o(frame_o), .frame_valid_o(frame_valid_o), .frame_ready_i(ready),
    .overrun_o(overrun_o), .conflict_cnt_o(conflict_cnt_o)
  );
  always #5 clk = ~clk;
  typedef struct { logic [6:0] oe; logic [6:0] o; logic [41:0] exp; } vec_t;
  vec_t tbl[8];
  logic [41:0] m_acc, m_frame;
  logic m_v, m_ov;
  int m_cnt, cyc, errors = 0, checks = 0;
  logic [6:0] p_o, p_oe;
  function automatic logic [41:0] lit_of(input logic [6:0] o, input logic [6:0] oe);
    int na = 0, a = 0;
    logic [41:0] r = '0;
    for (int p = 0; p < 7; p++) if (oe[p] && o[p]) begin na++; a = p; end
    if (na != 1) return '0;
    for (int c = 0; c < 7; c++) if (oe[c] && !o[c]) r[a*6 + (c < a ? c : c - 1)] = 1'b1;
    return r;
  endfunction
  function automatic bit is_conf(input logic [6:0] o, input logic [6:0] oe);
    return $countones(oe & o) >= 2 && (oe & ~o) != 0;
  endfunction
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  task automatic step(input logic [6:0] o, input logic [6:0] oe, input logic r);
    pin_o = o; pin_oe = oe; ready = r;
    m_acc |= lit_of(p_o, p_oe);
    if (is_conf(p_o, p_oe) && m_cnt < 255) m_cnt++;
    if (cyc % W == W - 1) begin
      if (!m_v || r) begin m_frame = m_acc; m_v = 1; end
      else m_ov = 1;
      m_acc = '0;
    end else if (m_v && r) m_v = 0;
    p_o = o; p_oe = oe; cyc++;
    @(negedge clk);
    chk("valid", 64'(frame_valid_o), 64'(m_v));
    chk("frame", 64'(frame_o), 64'(m_frame));
    chk("overrun", 64'(overrun_o), 64'(m_ov));
    chk("conflict_cnt", 64'(conflict_cnt_o), 64'(m_cnt));
  endtask
  task automatic hold(input logic [6:0] o, input logic [6:0] oe, input logic r, input int n);
    for (int i = 0; i < n; i++) step(o, oe, r);
  endtask
  task automatic align();
    while (cyc % W != 0) step('0, '0, 1'b1);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1; pin_o = '0; pin_oe = '0; ready = 1;
    #1;
    chk("rst_frame", 64'(frame_o), 0);
    chk("rst_valid", 64'(frame_valid_o), 0);
    chk("rst_overrun", 64'(overrun_o), 0);
    chk("rst_conflict", 64'(conflict_cnt_o), 0);
    m_acc = '0; m_frame = '0; m_v = 0; m_ov = 0; m_cnt = 0; cyc = 0; p_o = '0; p_oe = '0;
    @(negedge clk);
    rst = 0;
  endtask
  initial begin
    int pulses;
    logic [6:0] ro, roe;
    tbl[0] = '{7'b0000011, 7'b0000001, 42'h1};
    tbl[1] = '{7'b1000100, 7'b0000100, 42'h1 << 17};
    tbl[2] = '{7'b0000011, 7'b0000011, 42'h0};
    tbl[3] = '{7'h7F,      7'b0000011, 42'h0};
    tbl[4] = '{7'b1000001, 7'b1000000, 42'h1 << 36};
    tbl[5] = '{7'h7F,      7'b0000001, 42'h3F};
    tbl[6] = '{7'h7F,      7'b1000000, 42'h3F << 36};
    tbl[7] = '{7'b0000110, 7'b0000100, 42'h1 << 13};
    do_reset();
    pulses = 0;
    for (int i = 0; i < 2*W + 1; i++) begin
      step('0, '0, 1'b1);
      pulses += int'(frame_valid_o);
    end
    chk("idle_pulses", 64'(pulses), 2);
    chk("idle_frame", 64'(frame_o), 0);
    for (int i = 0; i < 8; i++) begin
      align();
      hold(tbl[i].o, tbl[i].oe, 1'b1, 2*W);
      chk($sformatf("tbl%0d_frame", i), 64'(frame_o), 64'(tbl[i].exp));
      chk($sformatf("tbl%0d_valid", i), 64'(frame_valid_o), 1);
    end
    align();
    hold('0, '0, 1'b1, W);
    hold('0, '0, 1'b1, 3);
    hold(7'b0000100, 7'b1000100, 1'b1, 10);
    hold('0, '0, 1'b1, W - 13);
    chk("mid_frame", 64'(frame_o), 64'(42'h1 << 17));
    hold('0, '0, 1'b1, W);
    chk("mid_next_frame", 64'(frame_o), 0);
    hold('0, '0, 1'b1, W - 1);
    step(7'b0000001, 7'b0000011, 1'b1);
    chk("lat_cur_frame", 64'(frame_o), 0);
    chk("lat_cur_valid", 64'(frame_valid_o), 1);
    hold('0, '0, 1'b1, W);
    chk("lat_next_frame", 64'(frame_o), 1);
    hold(7'b0000011, 7'h7F, 1'b1, 20*W);
    chk("conflict_sat", 64'(conflict_cnt_o), 255);
    chk("conflict_frame", 64'(frame_o), 0);
    align();
    hold(7'b0000001, 7'b0000011, 1'b1, W/2);
    do_reset();
    hold('0, '0, 1'b1, W);
    chk("rst_mid_frame", 64'(frame_o), 0);
    chk("rst_mid_valid", 64'(frame_valid_o), 1);
    do_reset();
    hold(7'b0000001, 7'b0000011, 1'b0, W);
    hold(7'b0000100, 7'b0000110, 1'b0, W);
    hold('0, '0, 1'b0, W);
    chk("ovr_frame", 64'(frame_o), 1);
    chk("ovr_valid", 64'(frame_valid_o), 1);
    chk("ovr_sticky", 64'(overrun_o), 1);
    step('0, '0, 1'b1);
    chk("ovr_drain_valid", 64'(frame_valid_o), 0);
    do_reset();
    for (int i = 0; i < 8*W; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        int k = $urandom_range(0, 7);
        ro = tbl[k].o; roe = tbl[k].oe;
      end else begin
        ro = 7'($urandom); roe = 7'($urandom);
      end
      step(ro, roe, $urandom_range(0, 2) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/charlie7x5_decoder.md
Name: charlie7x5_decoder

Overview:
- Receive-side counterpart of the charlie7x5 display driver.
- Samples the 7-pin charlieplex bus (output value plus output enable per pin) and decodes which LEDs are lit on each cycle.
- Accumulates lit LEDs over a fixed window and delivers one 42-bit frame snapshot per window over a valid/ready handshake.
- Used in the simulation top and benches to check what top actually displays; synthesizable for on-chip loopback.

Parameters:
- WINDOW_TICKS, 4096, clk cycles per accumulation window (≥2).
- ERR_W, 8, width of the saturating conflict counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- charlie7x5_o  input  7  pin output values from the driver.
- charlie7x5_oe  input  7  pin output enables from the driver (1 = driven).
- frame_o  output  42  lit-LED snapshot of the last completed window.
- frame_valid_o  output  1  frame_o holds an unconsumed snapshot.
- frame_ready_i  input  1  consumer accepts frame_o when high with frame_valid_o.
- overrun_o  output  1  sticky: a snapshot was dropped.
- conflict_cnt_o  output  ERR_W  saturating count of conflicting samples.

Behaviour:
- Reset (async assert, sync release):
  - frame_o=0, frame_valid_o=0, overrun_o=0, conflict_cnt_o=0.
  - Window counter=0, accumulator=0, input sample registers=0.
- Stage 1: charlie7x5_o and charlie7x5_oe are registered every cycle.
- Stage 2 decodes the registered sample. Per pin p:
  - anode if oe[p]&o[p].
  - cathode if oe[p]&~o[p].
  - hi-Z if ~oe[p].
- Lit set for the cycle:
  - Exactly one anode a and ≥1 cathode: each cathode c lights LED index a*6 + (c<a ? c : c-1), range 0..41.
  - No anode, or no cathodes: empty set; not an error.
  - ≥2 anodes and ≥1 cathode: conflict. Lit set is empty; conflict_cnt_o increments, saturating at 2^ERR_W-1.
- Accumulator: acc <= acc | lit_set every cycle.
- Window counter runs 0..WINDOW_TICKS-1 and wraps. On the cycle it equals WINDOW_TICKS-1 (window end):
  - snapshot = acc | lit_set for that cycle.
  - acc <= 0.
- Output register at window end:
  - If frame_valid_o=0, or frame_ready_i=1 that cycle: frame_o <= snapshot, frame_valid_o <= 1.
  - Otherwise the snapshot is discarded, frame_o holds its value, overrun_o <= 1 (sticky until reset).
- Handshake:
  - Transfer occurs on the cycle where frame_valid_o&frame_ready_i.
  - Not at window end: frame_valid_o <= 0.
  - At window end: the new snapshot loads and frame_valid_o stays 1 (back-to-back).
  - frame_o is stable while frame_valid_o=1 and not transferred.
- Latency: a pin pattern at the inputs on cycle n is in acc at cycle n+2. A pattern on cycle n is included in the window whose end cycle is ≥ n+1 (one-cycle input register shift).
- First window after reset is WINDOW_TICKS cycles long. The sample-register reset value is all-hi-Z, so it contributes nothing.
- Reset mid-window: the partial accumulation is discarded; the next window starts at counter 0 after release.

Optional Feature:
- Macro: CHARLIE7X5_DECODER_STATS_EN.
- Defined, adds two ports:
  - active_cycles_o  output  clog2(WINDOW_TICKS)+1: count of cycles in the last completed window with a non-empty lit set. Latched at window end together with frame_o, under the same accept/drop rule.
  - max_lit_o  output  3: largest number of simultaneously lit LEDs seen in that window (0..6).
- Not defined: neither port exists and no related logic is built; all other behaviour is identical.

Test Plan:
- Reset with all inputs 0, run 2*WINDOW_TICKS cycles with frame_ready_i=1 -> two frame_valid_o pulses, frame_o=0, conflict_cnt_o=0, overrun_o=0.
- Hold oe=7'b0000011, o=7'b0000001 (anode 0, cathode 1) for a full window -> frame_o has only bit 0 set.
- Hold oe=7'b1000100, o=7'b0000100 (anode 2, cathodes 6) for 10 cycles mid-window, then idle -> frame_o bit 17 set, all others 0. Next window frame_o=0.
- oe=7'h7F, o=7'b0000011 (two anodes) for 300 cycles with ERR_W=8 -> conflict_cnt_o=255 (saturated), frame_o=0.
- Keep frame_ready_i=0 for 3 windows -> frame_valid_o=1 holding the first snapshot, overrun_o=1. Raise ready for 1 cycle -> frame_valid_o falls next cycle.
- Pattern driven on the last input cycle of a window -> appears in the following window's frame, not the current one (latency check).
